// File: rtl/cp0_unit_pkg.sv
// CP0 register indices, exception codes and field positions
// shared by the coprocessor-0 unit and its users.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and
// exception arbitration, mfc0/mtc0 and eret support.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0077,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A,
  input  logic [31:0]        DIn,
  input  logic               we,
  input  logic [31:0]        PC_M,
  input  logic               BD_in,
  input  logic [4:0]         ExcCode_in,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXL_clr,
  output logic               int_exc_req,
  output logic [31:0]        EPC_out,
  output logic [31:0]        DOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [29:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        wr;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;
  logic        unused_pc;

  assign unused_pc = ^PC_M[1:0];

  always_comb begin
    int_req = reset & (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_req = reset & (ExcCode_in != 5'd0) & ~exl_q;
    int_exc_req = int_req | exc_req;
    wr = we & ~int_exc_req;
  end

  always_comb begin
    sr_word = 32'd0;
    sr_word[SR_IM_HI:SR_IM_LO] = im_q;
    sr_word[SR_EXL] = exl_q;
    sr_word[SR_IE] = ie_q;
    cause_word = 32'd0;
    cause_word[CAUSE_BD] = bd_q;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    epc_word = {epc_q, 2'b00};
  end

  always_comb begin
    DOut = 32'd0;
    unique case (1'b1)
      (A == CP0_SR):    DOut = sr_word;
      (A == CP0_CAUSE): DOut = cause_word;
      (A == CP0_EPC):   DOut = epc_word;
      (A == CP0_PRID):  DOut = PRID_VALUE;
      default:          DOut = 32'd0;
    endcase
  end

  // Bypass so an mtc0 EPC followed by eret sees the new value
  always_comb begin
    EPC_out = epc_word;
    if (we && (A == CP0_EPC)) begin
      EPC_out = {DIn[31:2], 2'b00};
    end
  end

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = HWInt;
    exc_d = exc_q;
    epc_d = epc_q;
    if (wr && (A == CP0_SR)) begin
      im_d  = DIn[SR_IM_HI:SR_IM_LO];
      exl_d = DIn[SR_EXL];
      ie_d  = DIn[SR_IE];
    end
    if (wr && (A == CP0_EPC)) begin
      epc_d = DIn[31:2];
    end
    if (EXL_clr) begin
      exl_d = 1'b0;
    end
    if (int_exc_req) begin
      exl_d = 1'b1;
      exc_d = int_req ? EXC_INT : ExcCode_in;
      bd_d  = BD_in;
      epc_d = BD_in ? (PC_M[31:2] - 30'd1)
                    : PC_M[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed and randomized checks of cp0_unit against
// a word-level model of the CP0 registers.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] PC_M;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXL_clr;
  logic        int_exc_req;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int n_cmp;
  int n_bad;

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  localparam logic [31:0] PRID = 32'h2021_0077;

  cp0_unit dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .DIn         (DIn),
    .we          (we),
    .PC_M        (PC_M),
    .BD_in       (BD_in),
    .ExcCode_in  (ExcCode_in),
    .HWInt       (HWInt),
    .EXL_clr     (EXL_clr),
    .int_exc_req (int_exc_req),
    .EPC_out     (EPC_out),
    .DOut        (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_int();
    logic [5:0] im;
    im = m_sr[15:10];
    return reset && ((HWInt & im) != 6'd0)
           && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return reset && (ExcCode_in != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_dout();
    case (A)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    if (we && A == 5'd14) return DIn & 32'hFFFF_FFFC;
    return m_epc;
  endfunction

  task automatic m_step();
    logic ir, er, rq;
    logic [31:0] ret;
    ir = m_int();
    er = m_exc();
    rq = ir || er;
    if (!reset) begin
      m_sr = 0;
      m_cause = 0;
      m_epc = 0;
      return;
    end
    m_cause = (m_cause & ~32'h0000_FC00)
              | (32'(HWInt) << 10);
    if (we && !rq && A == 5'd12)
      m_sr = DIn & 32'h0000_FC03;
    if (we && !rq && A == 5'd14)
      m_epc = DIn & 32'hFFFF_FFFC;
    if (EXL_clr) m_sr = m_sr & ~32'h2;
    if (rq) begin
      m_sr = m_sr | 32'h2;
      ret = BD_in ? PC_M - 32'd4 : PC_M;
      m_epc = ret & 32'hFFFF_FFFC;
      m_cause = (m_cause & 32'h0000_FC00)
                | (32'(BD_in) << 31)
                | ((ir ? 32'd0 : 32'(ExcCode_in)) << 2);
    end
  endtask

  task automatic run_cycle();
    #2;
    chk("req", 32'(int_exc_req),
        32'(m_int() || m_exc()));
    chk("dout", DOut, m_dout());
    chk("epc_out", EPC_out, m_epc_out());
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; DIn = 0; A = 5'd0; PC_M = 32'h3000;
    BD_in = 0; ExcCode_in = 0; HWInt = 0;
    EXL_clr = 0;
  endtask

  task automatic peek(input string tag,
                      input logic [4:0] idx,
                      input logic [31:0] exp);
    logic [4:0] a_sv;
    a_sv = A;
    A = idx;
    #1;
    chk(tag, DOut, exp);
    A = a_sv;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    reset = 0;
    @(negedge clk);

    HWInt = 6'h3F; ExcCode_in = 5'd4;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t1_rst_req", 32'(int_exc_req), 0);
      run_cycle();
    end
    reset = 1;
    idle();
    peek("t1_sr", 5'd12, 32'd0);
    peek("t1_cause", 5'd13, 32'd0);
    peek("t1_epc", 5'd14, 32'd0);

    we = 1; A = 5'd12; DIn = 32'h0000_0401;
    run_cycle();
    idle();
    HWInt = 6'h01; PC_M = 32'h3010;
    #1 chk("t2_req", 32'(int_exc_req), 1);
    run_cycle();
    idle();
    peek("t2_epc", 5'd14, 32'h3010);
    peek("t2_cause", 5'd13, 32'h0000_0400);
    peek("t2_sr", 5'd12, 32'h0000_0403);

    we = 1; A = 5'd12; DIn = 32'd0; EXL_clr = 1;
    run_cycle();
    idle();
    ExcCode_in = 5'd12; BD_in = 1; PC_M = 32'h3024;
    #1 chk("t3_req", 32'(int_exc_req), 1);
    run_cycle();
    idle();
    peek("t3_epc", 5'd14, 32'h3020);
    peek("t3_cause", 5'd13, 32'h8000_0030);

    we = 1; A = 5'd12; DIn = 32'h0000_1001; EXL_clr = 1;
    run_cycle();
    idle();
    HWInt = 6'h04; ExcCode_in = 5'd10;
    run_cycle();
    idle();
    peek("t4_cause", 5'd13, 32'h0000_1000);
    ExcCode_in = 5'd4;
    #1 chk("t4_nested", 32'(int_exc_req), 0);
    run_cycle();
    idle();

    we = 1; A = 5'd14; DIn = 32'h3047; EXL_clr = 1;
    #1 chk("t5_bypass", EPC_out, 32'h3044);
    run_cycle();
    idle();
    peek("t5_sr", 5'd12, 32'h0000_1001);
    peek("t5_epc", 5'd14, 32'h3044);

    we = 1; A = 5'd13; DIn = 32'hFFFF_FFFF;
    run_cycle();
    we = 1; A = 5'd15; DIn = 32'd0;
    run_cycle();
    idle();
    peek("t6_cause", 5'd13, 32'd0);
    peek("t6_prid", 5'd15, 32'h2021_0077);
    peek("t6_undef", 5'd3, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) != 0);
      A = 5'($urandom_range(10, 17));
      we = ($urandom_range(0, 3) == 0);
      DIn = $urandom;
      PC_M = $urandom;
      BD_in = 1'($urandom);
      ExcCode_in = ($urandom_range(0, 7) == 0)
                   ? 5'($urandom) : 5'd0;
      HWInt = ($urandom_range(0, 3) == 0)
              ? 6'($urandom) : 6'd0;
      EXL_clr = ($urandom_range(0, 5) == 0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
